// File: rtl/backprop_node.sv
// ---------------------------------------------------------------------------
// backprop_node
//
// Training-direction partner of the two-input forward neuron in the XOR
// fixed-point network. It owns the node's weight1, weight2 and bias registers,
// which feed the forward node. A start strobe runs one gradient-descent step
// that does three things:
//    - computes the back-propagated errors delta*w1 and delta*w2, using the
//      weights as they were before the step;
//    - updates both weights by w -= (LR*delta)*in;
//    - updates the bias by b -= LR*delta.
// All arithmetic is Q6.10 signed. A single 16x16 multiplier is shared
// between the steps, and the FSM state selects its operands.
//
// Ports:
//    clk                 rising-edge clock
//    rst_n               asynchronous active-low reset
//    start               run one step (sampled only in IDLE)
//    load                write w1_ld/w2_ld/b_ld (sampled only in IDLE,
//                        wins over start)
//    w1_ld, w2_ld, b_ld  parameter load values, Q6.10
//    in1, in2            forward inputs of this node, captured on start
//    delta               error term of this node, captured on start
//    weight1, weight2,
//    bias                current parameter registers
//    err1, err2          back-propagated errors (pre-update weights)
//    busy                high in every non-IDLE state
//    done                one-cycle pulse once every result of the step is valid
// ---------------------------------------------------------------------------
module backprop_node #(
   parameter logic signed [15:0] LR      = 16'sh0200,
   parameter logic signed [15:0] W1_INIT = 16'sh0000,
   parameter logic signed [15:0] W2_INIT = 16'sh0000,
   parameter logic signed [15:0] B_INIT  = 16'sh0000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               load,
   input  logic signed [15:0] w1_ld,
   input  logic signed [15:0] w2_ld,
   input  logic signed [15:0] b_ld,
   input  logic signed [15:0] in1,
   input  logic signed [15:0] in2,
   input  logic signed [15:0] delta,
   output logic signed [15:0] weight1,
   output logic signed [15:0] weight2,
   output logic signed [15:0] bias,
   output logic signed [15:0] err1,
   output logic signed [15:0] err2,
   output logic               busy,
   output logic               done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SCALE,
      S_ERR1,
      S_ERR2,
      S_W1,
      S_W2,
      S_B,
      S_DONE
   } state_t;

   state_t r_state;
   state_t w_nextState;

   logic signed [15:0] r_weight1;
   logic signed [15:0] r_weight2;
   logic signed [15:0] r_bias;
   logic signed [15:0] r_err1;
   logic signed [15:0] r_err2;
   logic signed [15:0] r_in1;
   logic signed [15:0] r_in2;
   logic signed [15:0] r_delta;
   logic signed [15:0] r_g;
   logic               r_done;

   logic signed [15:0] w_mulA;
   logic signed [15:0] w_mulB;
   logic signed [31:0] w_prod;
   logic signed [31:0] w_prodShift;
   logic signed [15:0] w_fmul;
   logic signed [15:0] w_subA;
   logic signed [15:0] w_subB;
   logic signed [16:0] w_diff;
   logic signed [15:0] w_ssub;

   // State register; reset aborts any step in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic. Load has priority over start in IDLE. Every other
   // state advances unconditionally, so strobes arriving mid-step are lost.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_IDLE: begin
            if (load) begin
               w_nextState = S_IDLE;
            end else if (start) begin
               w_nextState = S_SCALE;
            end
         end
         S_SCALE: w_nextState = S_ERR1;
         S_ERR1:  w_nextState = S_ERR2;
         S_ERR2:  w_nextState = S_W1;
         S_W1:    w_nextState = S_W2;
         S_W2:    w_nextState = S_B;
         S_B:     w_nextState = S_DONE;
         S_DONE:  w_nextState = S_IDLE;
         default: w_nextState = S_IDLE;
      endcase
   end

   // Operand selection for the single shared multiplier. The gradient scale
   // g = LR*delta is formed first, so both weight updates reuse it.
   always_comb begin
      w_mulA = 16'sd0;
      w_mulB = 16'sd0;
      case (r_state)
         S_SCALE: begin
            w_mulA = LR;
            w_mulB = r_delta;
         end
         S_ERR1: begin
            w_mulA = r_delta;
            w_mulB = r_weight1;
         end
         S_ERR2: begin
            w_mulA = r_delta;
            w_mulB = r_weight2;
         end
         S_W1: begin
            w_mulA = r_g;
            w_mulB = r_in1;
         end
         S_W2: begin
            w_mulA = r_g;
            w_mulB = r_in2;
         end
         default: begin
            w_mulA = 16'sd0;
            w_mulB = 16'sd0;
         end
      endcase
   end

   // Q6.10 multiply. The arithmetic shift floors toward minus infinity, so
   // -0.5 LSB becomes -1 LSB. The result is then clamped to the 16-bit range.
   always_comb begin
      w_prod      = w_mulA * w_mulB;
      w_prodShift = w_prod >>> 10;
      if (w_prodShift > 32'sd32767) begin
         w_fmul = 16'sh7FFF;
      end else if (w_prodShift < -32'sd32768) begin
         w_fmul = 16'sh8000;
      end else begin
         w_fmul = w_prodShift[15:0];
      end
   end

   // Saturating subtract for the parameter updates. Overflow shows up as a
   // mismatch between the two top bits of the 17-bit difference.
   always_comb begin
      w_subA = 16'sd0;
      w_subB = 16'sd0;
      case (r_state)
         S_W1: begin
            w_subA = r_weight1;
            w_subB = w_fmul;
         end
         S_W2: begin
            w_subA = r_weight2;
            w_subB = w_fmul;
         end
         S_B: begin
            w_subA = r_bias;
            w_subB = r_g;
         end
         default: begin
            w_subA = 16'sd0;
            w_subB = 16'sd0;
         end
      endcase
      w_diff = {w_subA[15], w_subA} - {w_subB[15], w_subB};
      if (w_diff[16] != w_diff[15]) begin
         w_ssub = w_diff[16] ? 16'sh8000 : 16'sh7FFF;
      end else begin
         w_ssub = w_diff[15:0];
      end
   end

   // Datapath registers. Each state writes only its own destination, so the
   // errors and parameters hold their values everywhere else. done is
   // registered from DONE, so it is high in the first IDLE cycle after a
   // step, when every result has already settled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_weight1 <= W1_INIT;
         r_weight2 <= W2_INIT;
         r_bias    <= B_INIT;
         r_err1    <= 16'sd0;
         r_err2    <= 16'sd0;
         r_in1     <= 16'sd0;
         r_in2     <= 16'sd0;
         r_delta   <= 16'sd0;
         r_g       <= 16'sd0;
         r_done    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (load) begin
                  r_weight1 <= w1_ld;
                  r_weight2 <= w2_ld;
                  r_bias    <= b_ld;
               end else if (start) begin
                  r_in1   <= in1;
                  r_in2   <= in2;
                  r_delta <= delta;
               end
            end
            S_SCALE: r_g       <= w_fmul;
            S_ERR1:  r_err1    <= w_fmul;
            S_ERR2:  r_err2    <= w_fmul;
            S_W1:    r_weight1 <= w_ssub;
            S_W2:    r_weight2 <= w_ssub;
            S_B:     r_bias    <= w_ssub;
            default: ;
         endcase
         r_done <= (r_state == S_DONE);
      end
   end

   assign weight1 = r_weight1;
   assign weight2 = r_weight2;
   assign bias    = r_bias;
   assign err1    = r_err1;
   assign err2    = r_err2;
   assign busy    = (r_state != S_IDLE);
   assign done    = r_done;

endmodule
